// File: rtl/aes_pkg.sv
// Shared AES-256 constants and GF(2^8) helpers used by the round-serial core.
package aes_pkg;

  localparam int         NUM_ROUNDS = 14;
  localparam logic [3:0] LAST_ROUND = 4'd14;

  // Round constant table, index 1..7 (AES-256 never needs more than seven).
  function automatic logic [7:0] rcon(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Multiply by x (0x02) in GF(2^8) with the AES polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column {a0,a1,a2,a3}, a0 in the top byte.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/aes_core_rs_sbox.sv
// Combinational forward AES S-box (module aes_sbox), table based.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Pure table lookup.
  always_comb begin
    out_byte = SBOX[in_byte];
  end

endmodule

// File: rtl/aes_core_rs.sv
// Round-serial AES-256 encryption core: one round per clock, key schedule
// expanded on the fly in a 256-bit window {RK(r-1), RK(r)}.
//
// Load handshake: a byte is transferred on a rising clk edge where valid and
// ready are both high. ready = !busy && !start; valid may toggle freely and
// a byte not accepted is simply not consumed.
module aes_core_rs
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_key_valid,
  input  logic [7:0]   ld_key_byte,
  output logic         ld_key_ready,
  input  logic         ld_state_valid,
  input  logic [7:0]   ld_state_byte,
  output logic         ld_state_ready,
  input  logic         start,
  output logic [127:0] state_out,
  output logic         done,
  output logic         round_done
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [255:0] key_q, key_d;
  logic [127:0] state_q, state_d;
  logic [255:0] kwin_q, kwin_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic         round_done_q, round_done_d;

  logic         busy;
  logic [127:0] sub_bytes;
  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [31:0]  sub_word;
  logic [31:0]  key_t;
  logic [127:0] next_rk;
  logic [127:0] cur_rk;

  assign busy           = (fsm_q == ST_BUSY);
  assign ld_key_ready   = !busy && !start;
  assign ld_state_ready = !busy && !start;
  assign state_out      = state_q;
  assign done           = done_q;
  assign round_done     = round_done_q;
  assign cur_rk         = kwin_q[127:0];

  // SubBytes: one S-box per state byte.
  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    aes_sbox u_sbox (
      .in_byte  (state_q[127-8*i -: 8]),
      .out_byte (sub_bytes[127-8*i -: 8])
    );
  end

  // SubWord on RK(r).w3 for the key schedule.
  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox u_sbox (
      .in_byte  (kwin_q[31-8*i -: 8]),
      .out_byte (sub_word[31-8*i -: 8])
    );
  end

  // ShiftRows then MixColumns; byte (row + 4*col), row r rotates left by r.
  always_comb begin
    shifted = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(r+4*c) -: 8] = sub_bytes[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
  end

  // Next round key. Rot and Sub commute, so rotate the substituted word.
  // r+1 even (r odd) is a full-schedule step with Rcon[(r+1)/2].
  always_comb begin
    if (round_q[0]) begin
      key_t = {sub_word[23:0], sub_word[31:24]} ^ {rcon(round_q[3:1] + 3'd1), 24'h0};
    end else begin
      key_t = sub_word;
    end
    next_rk[127:96] = kwin_q[255:224] ^ key_t;
    next_rk[95:64]  = kwin_q[223:192] ^ next_rk[127:96];
    next_rk[63:32]  = kwin_q[191:160] ^ next_rk[95:64];
    next_rk[31:0]   = kwin_q[159:128] ^ next_rk[63:32];
  end

  // Next-state: byte loads while idle, start launches round 1, then one round per cycle.
  always_comb begin
    fsm_d        = fsm_q;
    key_d        = key_q;
    state_d      = state_q;
    kwin_d       = kwin_q;
    round_d      = round_q;
    done_d       = done_q;
    round_done_d = 1'b0;
    if (!busy) begin
      if (start) begin
        fsm_d   = ST_BUSY;
        done_d  = 1'b0;
        round_d = 4'd1;
        state_d = state_q ^ key_q[255:128];
        kwin_d  = key_q;
      end else begin
        if (ld_key_valid) begin
          key_d = {key_q[247:0], ld_key_byte};
        end
        if (ld_state_valid) begin
          state_d = {state_q[119:0], ld_state_byte};
        end
      end
    end else begin
      round_done_d = 1'b1;
      kwin_d       = {kwin_q[127:0], next_rk};
      if (round_q == LAST_ROUND) begin
        state_d = shifted ^ cur_rk;
        fsm_d   = ST_IDLE;
        done_d  = 1'b1;
        round_d = 4'd0;
      end else begin
        state_d = mixed ^ cur_rk;
        round_d = round_q + 4'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= ST_IDLE;
      key_q        <= '0;
      state_q      <= '0;
      kwin_q       <= '0;
      round_q      <= '0;
      done_q       <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      key_q        <= key_d;
      state_q      <= state_d;
      kwin_q       <= kwin_d;
      round_q      <= round_d;
      done_q       <= done_d;
      round_done_q <= round_done_d;
    end
  end

endmodule

// File: tb/tb_aes_core_rs.sv
// Directed bench for aes_core_rs: FIPS-197 C.3, zero vector, key reuse,
// busy behaviour, mid-run reset and gapped concurrent loading.
module tb_aes_core_rs;

  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_Z   = 128'hdc95c078a2408989ad48a21492842087;

  logic         clk;
  logic         rst_n;
  logic         ld_key_valid;
  logic [7:0]   ld_key_byte;
  logic         ld_key_ready;
  logic         ld_state_valid;
  logic [7:0]   ld_state_byte;
  logic         ld_state_ready;
  logic         start;
  logic [127:0] state_out;
  logic         done;
  logic         round_done;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];
  logic         done_prev = 1'b0;

  aes_core_rs dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld_key_valid   (ld_key_valid),
    .ld_key_byte    (ld_key_byte),
    .ld_key_ready   (ld_key_ready),
    .ld_state_valid (ld_state_valid),
    .ld_state_byte  (ld_state_byte),
    .ld_state_ready (ld_state_ready),
    .start          (start),
    .state_out      (state_out),
    .done           (done),
    .round_done     (round_done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every rising done must match the oldest expectation.
  always @(negedge clk) begin
    logic [127:0] exp;
    if (done && !done_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: state_out=%h with no expected result queued", state_out);
      end else begin
        exp = exp_q.pop_front();
        if (state_out !== exp) begin
          errors++;
          $display("FAIL ciphertext: got %h expected %h", state_out, exp);
        end
      end
    end
    done_prev = done;
  end

  task automatic check1(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Driver: stream key and/or plaintext bytes, optionally with random valid gaps.
  task automatic load_data(input logic [255:0] key, input bit do_key,
                           input logic [127:0] pt, input bit do_pt, input bit gaps);
    int ki;
    int si;
    int cyc;
    bit acc_k;
    bit acc_s;
    ki  = do_key ? 0 : 32;
    si  = do_pt ? 0 : 16;
    cyc = 0;
    while ((ki < 32 || si < 16) && cyc < 500) begin
      ld_key_valid   = 1'b0;
      ld_key_byte    = 8'h00;
      ld_state_valid = 1'b0;
      ld_state_byte  = 8'h00;
      if (ki < 32 && (!gaps || $urandom_range(0, 1) == 1)) begin
        ld_key_valid = 1'b1;
        ld_key_byte  = key[255-8*ki -: 8];
      end
      if (si < 16 && (!gaps || $urandom_range(0, 1) == 1)) begin
        ld_state_valid = 1'b1;
        ld_state_byte  = pt[127-8*si -: 8];
      end
      acc_k = ld_key_valid && ld_key_ready;
      acc_s = ld_state_valid && ld_state_ready;
      @(posedge clk); #1;
      if (acc_k) ki++;
      if (acc_s) si++;
      cyc++;
    end
    ld_key_valid   = 1'b0;
    ld_state_valid = 1'b0;
    check1("load_complete", 128'((ki == 32 && si == 16) ? 1 : 0), 128'd1);
  endtask

  // Driver: pulse start, optionally disturb the run, and check timing and handshake.
  task automatic run_block(input logic [127:0] exp, input bit disturb);
    int cnt;
    int rd;
    bit rdy_bad;
    exp_q.push_back(exp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check1("done_cleared_at_start", 128'(done), 128'd0);
    cnt     = 0;
    rd      = 0;
    rdy_bad = 1'b0;
    while (!done && cnt < 40) begin
      if (ld_key_ready || ld_state_ready) rdy_bad = 1'b1;
      if (disturb) begin
        ld_key_valid   = 1'b1;
        ld_key_byte    = 8'($urandom_range(0, 255));
        ld_state_valid = 1'b1;
        ld_state_byte  = 8'($urandom_range(0, 255));
        start          = (cnt == 5);
      end
      @(posedge clk); #1;
      cnt++;
      if (round_done) rd++;
    end
    start          = 1'b0;
    ld_key_valid   = 1'b0;
    ld_state_valid = 1'b0;
    check1("latency_cycles", 128'(cnt), 128'd14);
    check1("round_done_pulses", 128'(rd), 128'd14);
    check1("ready_low_while_busy", 128'(rdy_bad), 128'd0);
    @(posedge clk); #1;
    check1("round_done_idle", 128'(round_done), 128'd0);
    check1("done_held", 128'(done), 128'd1);
  endtask

  // Stimulus sequence
  initial begin
    int rd;
    int guard;
    rst_n          = 1'b0;
    start          = 1'b0;
    ld_key_valid   = 1'b0;
    ld_key_byte    = 8'h00;
    ld_state_valid = 1'b0;
    ld_state_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_state_out", state_out, 128'd0);
    check1("reset_done", 128'(done), 128'd0);
    check1("reset_round_done", 128'(round_done), 128'd0);
    check1("reset_ready", 128'({ld_key_ready, ld_state_ready}), 128'd3);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.3
    load_data(KEY_C3, 1'b1, PT_C3, 1'b1, 1'b0);
    run_block(CT_C3, 1'b0);

    // Key reuse: plaintext only
    load_data(KEY_C3, 1'b0, PT_C3, 1'b1, 1'b0);
    check1("load_keeps_done", 128'(done), 128'd1);
    run_block(CT_C3, 1'b0);

    // All-zero key and plaintext
    load_data(256'd0, 1'b1, 128'd0, 1'b1, 1'b0);
    run_block(CT_Z, 1'b0);

    // Busy behaviour: junk bytes and a second start during the run
    load_data(KEY_C3, 1'b1, PT_C3, 1'b1, 1'b0);
    run_block(CT_C3, 1'b1);

    // Reset mid-encryption
    load_data(KEY_C3, 1'b1, PT_C3, 1'b1, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rd    = 0;
    guard = 0;
    while (rd < 6 && guard < 40) begin
      @(posedge clk); #1;
      if (round_done) rd++;
      guard++;
    end
    check1("reached_round_7", 128'(rd), 128'd6);
    #2 rst_n = 1'b0;
    #1;
    check1("midreset_done", 128'(done), 128'd0);
    check1("midreset_state_out", state_out, 128'd0);
    check1("midreset_ready", 128'({ld_key_ready, ld_state_ready}), 128'd3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Gapped, concurrent key and state loads
    load_data(KEY_C3, 1'b1, PT_C3, 1'b1, 1'b1);
    run_block(CT_C3, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check1("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_core_rs.md
Name: aes_core_rs

Overview:
- Round-serial AES-256 encryption core; one full AES round per clock, with on-the-fly key expansion.
- Key (32 bytes) and plaintext block (16 bytes) are loaded byte-serially, MSB-first, over valid/ready handshakes.
- A 1-cycle start pulse launches encryption; the ciphertext is presented on a 128-bit parallel output.
- Sits under the bus-facing AES wrapper, which streams bytes in and out of it. Encryption only; no decrypt path.

Parameters:
- None. AES-256 is fixed: 14 rounds, 256-bit key.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ld_key_valid  in  1  key byte present.
- ld_key_byte  in  8  key byte, MSB-first order.
- ld_key_ready  out  1  core accepts a key byte.
- ld_state_valid  in  1  plaintext byte present.
- ld_state_byte  in  8  plaintext byte, MSB-first order.
- ld_state_ready  out  1  core accepts a plaintext byte.
- start  in  1  1-cycle pulse that begins encryption.
- state_out  out  128  state register; holds the ciphertext once done=1.
- done  out  1  level: encryption complete, result valid.
- round_done  out  1  debug pulse, one per completed round.

Behaviour:
- Reset: key_reg=0, state_reg=0, busy=0, round counter=0, done=0, round_done=0, state_out=0.
- Ready outputs: ld_key_ready = ld_state_ready = !busy && !start (combinational).
- Key load: on ld_key_valid&&ld_key_ready, key_reg <= {key_reg[247:0], byte}. After 32 bytes the first byte sits in [255:248]. There is no byte counter; extra bytes keep shifting.
- State load: on ld_state_valid&&ld_state_ready, state_reg <= {state_reg[119:0], byte}. After 16 bytes the first byte (FIPS-197 byte 0) sits in [127:120]. Both load paths may accept a byte in the same cycle.
- Loading does not affect done.
- Start (when !busy): busy<=1, done<=0, round<=1.
  - state_reg <= state_reg ^ key_reg[255:128] (AddRoundKey 0).
  - kwin <= key_reg (256-bit window {RK0,RK1}).
  - start while busy is ignored. Any load byte in the start cycle is not accepted (ready low).
- Round r, one per cycle, r=1..14, with kwin={RK(r-1),RK(r)}:
  - Rounds 1..13: state <= MixColumns(ShiftRows(SubBytes(state))) ^ RK(r).
  - Round 14: MixColumns is omitted.
  - Next window: kwin <= {RK(r), RK(r+1)}, where RK(r+1) words n0..n3 are:
    - n0 = RK(r-1).w0 ^ T, and n(i) = RK(r-1).w(i) ^ n(i-1).
    - T = SubWord(RotWord(RK(r).w3)) ^ {Rcon[(r+1)/2],24'h0} when r+1 is even.
    - T = SubWord(RK(r).w3) when r+1 is odd.
    - Rcon[1..7] = 01,02,04,08,10,20,40.
  - round_done pulses high for 1 cycle after each round's register update (14 pulses per block).
- Completion:
  - After round 14: busy<=0, done<=1.
  - Latency: start sampled at edge T0 gives done=1 and a valid state_out immediately after edge T14.
  - done stays high until the next accepted start, or reset.
- Byte/column order: state_out[127-8i -: 8] is output byte i, column-major per FIPS-197.
- Start issued with a partially loaded key or state: the core encrypts whatever the registers currently hold.
- Reset mid-encryption: returns all registers to reset values at once; done=0.
- key_reg is preserved across encryptions; the same key can be reused with only a new state loaded.

Decomposition:
- Package aes_pkg:
  - NUM_ROUNDS=14.
  - Rcon table.
  - xtime/GF(2^8) multiply-by-2 function.
  - MixColumns single-column function.
- Sub-module aes_sbox: combinational 8-bit forward S-box.
  - 16 instances for SubBytes.
  - 4 instances for SubWord.

Test Plan:
- FIPS-197 C.3 vector:
  - Stimulus: load key 000102..1f (32 bytes), plaintext 00112233445566778899aabbccddeeff, pulse start.
  - Response: done rises exactly 14 cycles after start; state_out = 8ea2b7ca516745bfeafc49904b496089; 14 round_done pulses.
- Zero vector: all-zero key and plaintext, start -> state_out = dc95c078a2408989ad48a21492842087.
- Key reuse: after the C.3 run, reload only the plaintext with 00112233..ff and start again -> same ciphertext. done is 0 from the start until completion.
- Busy behaviour: during encryption, both ready outputs = 0.
  - Valid bytes driven during encryption are ignored, so the result is unchanged.
  - A second start mid-run is ignored, so completion still happens at T14.
- Reset mid-operation: assert rst_n=0 at round 7 -> done=0, state_out=0, ready=1; a subsequent full load plus start gives correct C.3 output.
- Handshake gaps: valid deasserted randomly between bytes, and key and state loads in the same cycles -> correct C.3 ciphertext.
